// File: rtl/frame_buffer_pkg.sv
// Shared types and helpers for the frame_buffer_2p frame store.
package frame_buffer_pkg;

  localparam int LINES_DEF   = 176;
  localparam int COLUMNS_DEF = 288;
  localparam int S_DATA_DEF  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } fb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int lin_addr(input int line, input int column, input int columns);
    return line * columns + column;
  endfunction

endpackage

// File: rtl/frame_buffer_bank.sv
// Plain 1-write/1-read synchronous RAM: read-first, registered output, no reset.
module frame_buffer_bank #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 50688
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/frame_buffer_2p.sv
// Dual-port line/column frame store with zeroing sweep and range checks.
// Optional macro FB_PINGPONG_EN adds a second bank and a swap input.
module frame_buffer_2p
  import frame_buffer_pkg::*;
#(
  parameter int LINES    = LINES_DEF,
  parameter int COLUMNS  = COLUMNS_DEF,
  parameter int S_DATA   = S_DATA_DEF,
  parameter int S_LINE   = 8,
  parameter int S_COLUMN = 9
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                wipe,
`ifdef FB_PINGPONG_EN
  input  logic                swap,
`endif
  input  logic                we,
  input  logic [S_LINE-1:0]   wr_line,
  input  logic [S_COLUMN-1:0] wr_column,
  input  logic [S_DATA-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [S_LINE-1:0]   rd_line,
  input  logic [S_COLUMN-1:0] rd_column,
  output logic [S_DATA-1:0]   rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic                sweep_done,
  output logic                oob_err,
  output logic                bank_sel
);

`ifdef FB_PINGPONG_EN
  localparam int BANKS = 2;
`else
  localparam int BANKS = 1;
`endif
  localparam int DEPTH = LINES * COLUMNS;
  localparam int AW    = clog2(DEPTH);
  localparam int CW    = clog2(DEPTH * BANKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH * BANKS - 1);

  fb_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_zero_q, rd_zero_d;
  logic              sweep_done_q, sweep_done_d;
  logic              oob_err_q, oob_err_d;
  logic              bank_sel_q, bank_sel_d;
  logic              idle, wr_ok, rd_ok, rd_from;
  logic [AW-1:0]     wr_addr, rd_addr, sweep_addr, mem_waddr;
  logic [S_DATA-1:0] mem_wdata;
  logic              mem_we, mem_re, mem_wbank, sweep_bank;
  logic [S_DATA-1:0] bank_rdata [BANKS];

  assign idle    = (state_q == IDLE);
  assign wr_ok   = (int'(wr_line) < LINES) && (int'(wr_column) < COLUMNS);
  assign rd_ok   = (int'(rd_line) < LINES) && (int'(rd_column) < COLUMNS);
  assign wr_addr = AW'(lin_addr(int'(wr_line), int'(wr_column), COLUMNS));
  assign rd_addr = AW'(lin_addr(int'(rd_line), int'(rd_column), COLUMNS));

`ifdef FB_PINGPONG_EN
  // The sweep counter spans both banks: low half clears bank 0, high half bank 1.
  assign sweep_bank = (cnt_q >= CW'(DEPTH));
  assign sweep_addr = sweep_bank ? AW'(cnt_q - CW'(DEPTH)) : AW'(cnt_q);
  assign rd_from    = !bank_sel_q;
`else
  assign sweep_bank = 1'b0;
  assign sweep_addr = AW'(cnt_q);
  assign rd_from    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_valid_d   = rd_en;
    rd_zero_d    = rd_zero_q;
    sweep_done_d = 1'b0;
    oob_err_d    = (we && idle && !wr_ok) || (rd_en && !rd_ok);
    bank_sel_d   = bank_sel_q;
    mem_we       = 1'b0;
    mem_waddr    = wr_addr;
    mem_wdata    = wr_data;
    mem_wbank    = bank_sel_q;
    mem_re       = rd_en && idle && rd_ok;
    // rd_data is forced to zero for sweep-time or out-of-range reads and after reset.
    if (rd_en) rd_zero_d = !(idle && rd_ok);
    case (state_q)
      IDLE: begin
        mem_we = we && wr_ok;
        if (wipe) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
`ifdef FB_PINGPONG_EN
        if (swap) bank_sel_d = !bank_sel_q;
`endif
      end
      SWEEP: begin
        mem_we    = 1'b1;
        mem_waddr = sweep_addr;
        mem_wdata = '0;
        mem_wbank = sweep_bank;
        if (cnt_q == CNT_LAST) begin
          state_d      = IDLE;
          sweep_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SWEEP;
    endcase
    if (clear) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q      <= SWEEP;
      cnt_q        <= '0;
      rd_valid_q   <= 1'b0;
      rd_zero_q    <= 1'b1;
      sweep_done_q <= 1'b0;
      oob_err_q    <= 1'b0;
      bank_sel_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_valid_q   <= rd_valid_d;
      rd_zero_q    <= rd_zero_d;
      sweep_done_q <= sweep_done_d;
      oob_err_q    <= oob_err_d;
      bank_sel_q   <= bank_sel_d;
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    frame_buffer_bank #(
      .DATA_W(S_DATA),
      .ADDR_W(AW),
      .DEPTH (DEPTH)
    ) u_bank (
      .clk  (clk),
      .we   (mem_we && (mem_wbank == 1'(b))),
      .waddr(mem_waddr),
      .wdata(mem_wdata),
      .re   (mem_re && (rd_from == 1'(b))),
      .raddr(rd_addr),
      .rdata(bank_rdata[b])
    );
  end

`ifdef FB_PINGPONG_EN
  logic rd_bank_q, rd_bank_d;

  always_comb begin
    rd_bank_d = rd_bank_q;
    if (mem_re) rd_bank_d = rd_from;
  end

  always_ff @(posedge clk) rd_bank_q <= rd_bank_d;

  assign rd_data = rd_zero_q ? '0 : bank_rdata[rd_bank_q];
`else
  assign rd_data = rd_zero_q ? '0 : bank_rdata[0];
`endif

  assign rd_valid   = rd_valid_q;
  assign busy       = (state_q == SWEEP);
  assign sweep_done = sweep_done_q;
  assign oob_err    = oob_err_q;
  assign bank_sel   = bank_sel_q;

endmodule

// File: tb/tb_frame_buffer_2p.sv
// Directed, table-driven bench for frame_buffer_2p on a 4x6 frame.
module tb_frame_buffer_2p;

  localparam int LINES    = 4;
  localparam int COLUMNS  = 6;
  localparam int S_DATA   = 8;
  localparam int S_LINE   = 3;
  localparam int S_COLUMN = 3;
  localparam int DEPTH    = LINES * COLUMNS;
`ifdef FB_PINGPONG_EN
  localparam int BANKS = 2;
`else
  localparam int BANKS = 1;
`endif

  logic                clk = 1'b0;
  logic                clear, wipe, we, rd_en;
  logic [S_LINE-1:0]   wr_line, rd_line;
  logic [S_COLUMN-1:0] wr_column, rd_column;
  logic [S_DATA-1:0]   wr_data, rd_data;
  logic                rd_valid, busy, sweep_done, oob_err, bank_sel;
`ifdef FB_PINGPONG_EN
  logic                swap;
`endif

  int errors = 0;
  int checks = 0;

  frame_buffer_2p #(
    .LINES(LINES), .COLUMNS(COLUMNS), .S_DATA(S_DATA), .S_LINE(S_LINE), .S_COLUMN(S_COLUMN)
  ) dut (
    .clk(clk), .clear(clear), .wipe(wipe),
`ifdef FB_PINGPONG_EN
    .swap(swap),
`endif
    .we(we), .wr_line(wr_line), .wr_column(wr_column), .wr_data(wr_data),
    .rd_en(rd_en), .rd_line(rd_line), .rd_column(rd_column),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .sweep_done(sweep_done), .oob_err(oob_err), .bank_sel(bank_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [2:0] wl, wc;
    logic [7:0] wd;
    logic       re;
    logic [2:0] rl, rc;
    logic       ev;
    logic [7:0] ed;
    logic       eo;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic w, input int wl, input int wc, input int wd,
                              input logic r, input int rl, input int rc,
                              input logic ev, input int ed, input logic eo);
    vec_t v;
    v.we = w;  v.wl = 3'(wl); v.wc = 3'(wc); v.wd = 8'(wd);
    v.re = r;  v.rl = 3'(rl); v.rc = 3'(rc);
    v.ev = ev; v.ed = 8'(ed); v.eo = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rest_inputs();
    clear = 1'b0; wipe = 1'b0; we = 1'b0; rd_en = 1'b0;
    wr_line = '0; wr_column = '0; wr_data = '0; rd_line = '0; rd_column = '0;
`ifdef FB_PINGPONG_EN
    swap = 1'b0;
`endif
  endtask

  task automatic read_cell(input int l, input int c, input logic [7:0] exp, input string name);
    rd_en = 1'b1; rd_line = 3'(l); rd_column = 3'(c);
    step();
    rd_en = 1'b0;
    chk({name, " valid"}, rd_valid, 1);
    chk({name, " data"}, rd_data, exp);
  endtask

  // Called right after the edge that starts a sweep; counts busy cycles and pokes it mid-way.
  task automatic run_sweep(input string tag);
    int  n;
    bit  ended;
    n = 1;
    ended = 0;
    chk({tag, " busy start"}, busy, 1);
    for (int k = 0; k < 200 && !ended; k++) begin
      if (n == 20) begin we = 1'b1; wr_line = 3'd0; wr_column = 3'd0; wr_data = 8'h77; end
      if (n == 21) begin rd_en = 1'b1; rd_line = 3'd3; rd_column = 3'd5; end
      step();
      we = 1'b0; rd_en = 1'b0;
      if (n == 21) begin
        chk({tag, " sweep read valid"}, rd_valid, 1);
        chk({tag, " sweep read data"}, rd_data, 0);
      end
      if (!busy) begin
        ended = 1;
        chk({tag, " busy length"}, n, DEPTH * BANKS);
        chk({tag, " sweep_done pulse"}, sweep_done, 1);
      end else begin
        n++;
      end
    end
    if (!ended) chk({tag, " sweep timeout"}, busy, 0);
    step();
    chk({tag, " sweep_done single"}, sweep_done, 0);
  endtask

  initial begin
    vecs[0]  = mk(1, 3, 5, 'hA5, 0, 0, 0, 0, 'h00, 0);
    vecs[1]  = mk(0, 0, 0, 0,    1, 3, 5, 1, 'hA5, 0);
    vecs[2]  = mk(0, 0, 0, 0,    1, 0, 0, 1, 'h00, 0);
    vecs[3]  = mk(1, 2, 2, 'h11, 0, 0, 0, 0, 'h00, 0);
    vecs[4]  = mk(1, 2, 2, 'h22, 1, 2, 2, 1, 'h11, 0);
    vecs[5]  = mk(0, 0, 0, 0,    1, 2, 2, 1, 'h22, 0);
    vecs[6]  = mk(1, 4, 0, 'hFF, 0, 0, 0, 0, 'h22, 1);
    vecs[7]  = mk(0, 0, 0, 0,    0, 0, 0, 0, 'h22, 0);
    vecs[8]  = mk(0, 0, 0, 0,    1, 0, 6, 1, 'h00, 1);
    vecs[9]  = mk(1, 1, 7, 'hFF, 0, 0, 0, 0, 'h00, 1);
    vecs[10] = mk(0, 0, 0, 0,    1, 2, 1, 1, 'h00, 0);
    vecs[11] = mk(0, 0, 0, 0,    1, 3, 5, 1, 'hA5, 0);
    vecs[12] = mk(1, 4, 7, 'hEE, 1, 5, 0, 1, 'h00, 1);
    vecs[13] = mk(0, 0, 0, 0,    0, 0, 0, 0, 'h00, 0);
    vecs[14] = mk(1, 0, 0, 'h5A, 1, 0, 0, 1, 'h00, 0);
    vecs[15] = mk(0, 0, 0, 0,    1, 0, 0, 1, 'h5A, 0);
    vecs[16] = mk(0, 0, 0, 0,    1, 2, 2, 1, 'h22, 0);

    rest_inputs();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("reset rd_valid", rd_valid, 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset oob_err", oob_err, 0);
    chk("reset sweep_done", sweep_done, 0);
    chk("reset bank_sel", bank_sel, 0);
    run_sweep("init");

    for (int a = 0; a < DEPTH; a++)
      read_cell(a / COLUMNS, a % COLUMNS, 8'h00, $sformatf("init zero %0d", a));

    for (int i = 0; i < 17; i++) begin
      we = vecs[i].we; wr_line = vecs[i].wl; wr_column = vecs[i].wc; wr_data = vecs[i].wd;
      rd_en = vecs[i].re; rd_line = vecs[i].rl; rd_column = vecs[i].rc;
      step();
      we = 1'b0; rd_en = 1'b0;
      chk($sformatf("vec%0d rd_valid", i), rd_valid, vecs[i].ev);
      chk($sformatf("vec%0d rd_data", i), rd_data, vecs[i].ed);
      chk($sformatf("vec%0d oob_err", i), oob_err, vecs[i].eo);
    end

    wipe = 1'b1;
    step();
    wipe = 1'b0;
    chk("wipe busy", busy, 1);
    for (int k = 0; k < 9; k++) step();
    chk("wipe busy at cycle 10", busy, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    run_sweep("restart");

    for (int a = 0; a < DEPTH; a++)
      read_cell(a / COLUMNS, a % COLUMNS, 8'h00, $sformatf("wiped zero %0d", a));

`ifdef FB_PINGPONG_EN
    we = 1'b1; wr_line = 3'd1; wr_column = 3'd1; wr_data = 8'h33;
    step();
    we = 1'b0;
    swap = 1'b1;
    step();
    swap = 1'b0;
    chk("pp bank_sel after swap", bank_sel, 1);
    read_cell(1, 1, 8'h33, "pp read bank0");
    we = 1'b1; wr_line = 3'd1; wr_column = 3'd1; wr_data = 8'h44;
    step();
    we = 1'b0;
    read_cell(1, 1, 8'h33, "pp read still bank0");
    swap = 1'b1;
    step();
    swap = 1'b0;
    chk("pp bank_sel back", bank_sel, 0);
    read_cell(1, 1, 8'h44, "pp read bank1");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
